// File: rtl/pc_gen_pkg.sv
// Shared constants for the fetch-stage program-counter generator.
// Holds the pcsel codes, default vector addresses and the boot/run state type.
package pc_gen_pkg;

    localparam int unsigned ID_W  = 16;
    localparam int unsigned SEL_W = 3;

    localparam logic [SEL_W-1:0] PCSEL_INC   = 3'd0;
    localparam logic [SEL_W-1:0] PCSEL_BR    = 3'd1;
    localparam logic [SEL_W-1:0] PCSEL_JMP   = 3'd2;
    localparam logic [SEL_W-1:0] PCSEL_ILLOP = 3'd3;
    localparam logic [SEL_W-1:0] PCSEL_XADR  = 3'd4;

    localparam logic [31:0] DEF_RESET_ADDR = 32'h8000_0000;
    localparam logic [31:0] DEF_ILLOP_ADDR = 32'h8000_0004;
    localparam logic [31:0] DEF_XADR_ADDR  = 32'h8000_0008;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/pc_gen_irq_sync.sv
// Multi-flop synchroniser bringing the asynchronous irq level into the clock domain.
module pc_gen_irq_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic irq,
    output logic irq_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], irq};
        end
    end

    assign irq_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: boot hold, stall, branch/jump/trap
// redirects and a latched external interrupt that is masked while in supervisor mode.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR  = WIDTH'(DEF_RESET_ADDR),
    parameter logic [WIDTH-1:0] ILLOP_ADDR  = WIDTH'(DEF_ILLOP_ADDR),
    parameter logic [WIDTH-1:0] XADR_ADDR   = WIDTH'(DEF_XADR_ADDR),
    parameter int unsigned      BOOT_CYCLES = 2,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic [SEL_W-1:0] pcsel,
    input  logic [ID_W-1:0]  id,
    input  logic [WIDTH-1:0] jt,
    input  logic             irq,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_inc,
    output logic [WIDTH-1:0] pc_offset,
    output logic             supervisor,
    output logic             fetch_valid,
    output logic             irq_taken
);

    localparam int unsigned      LOW_W     = WIDTH - 1;
    localparam int unsigned      CNT_W     = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'((BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0);
    localparam state_e           ST_INIT   = (BOOT_CYCLES == 0) ? ST_RUN : ST_BOOT;

    state_e           r_state;
    logic [CNT_W-1:0] r_boot_cnt;
    logic [WIDTH-1:0] r_pc;
    logic             r_pending;
    logic             r_irq_taken;

    logic             w_irq_sync;
    logic             w_take;
    logic [LOW_W-1:0] w_low_inc;
    logic [LOW_W-1:0] w_sext;
    logic [LOW_W-1:0] w_low_off;
    logic [WIDTH-1:0] w_pc_jmp;
    logic [WIDTH-1:0] w_pc_next;
    logic             w_unused_jt;

    pc_gen_irq_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_irq_sync (
        .clock   (clock),
        .reset   (reset),
        .irq     (irq),
        .irq_sync(w_irq_sync)
    );

    // Low field wraps on its own; the supervisor bit is never carried into.
    assign w_low_inc = r_pc[WIDTH-2:0] + LOW_W'(4);
    assign w_sext    = {{(WIDTH-17){id[ID_W-1]}}, id, 2'b00};
    assign w_low_off = w_low_inc + w_sext;
    assign w_pc_jmp  = {r_pc[WIDTH-1] & jt[WIDTH-1], jt[WIDTH-2:2], 2'b00};
    assign w_unused_jt = ^jt[1:0];

    assign w_take = (r_state == ST_RUN) && !stall && r_pending && !r_pc[WIDTH-1];

    always_comb begin
        w_pc_next = {r_pc[WIDTH-1], w_low_inc};
        if (w_take) begin
            w_pc_next = XADR_ADDR;
        end else begin
            case (pcsel)
                PCSEL_XADR:  w_pc_next = XADR_ADDR;
                PCSEL_ILLOP: w_pc_next = ILLOP_ADDR;
                PCSEL_JMP:   w_pc_next = w_pc_jmp;
                PCSEL_BR:    w_pc_next = {r_pc[WIDTH-1], w_low_off};
                PCSEL_INC:   w_pc_next = {r_pc[WIDTH-1], w_low_inc};
                default:     w_pc_next = {r_pc[WIDTH-1], w_low_inc};
            endcase
        end
    end

    // Pending keeps latching during boot, stall and supervisor mode; only a take clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_boot_cnt  <= '0;
            r_pc        <= RESET_ADDR;
            r_pending   <= 1'b0;
            r_irq_taken <= 1'b0;
        end else begin
            r_irq_taken <= 1'b0;
            if (w_take) begin
                r_pending <= 1'b0;
            end else if (w_irq_sync) begin
                r_pending <= 1'b1;
            end
            if (r_state == ST_BOOT) begin
                if (r_boot_cnt == BOOT_LAST) begin
                    r_state <= ST_RUN;
                end else begin
                    r_boot_cnt <= r_boot_cnt + CNT_W'(1);
                end
            end else if (!stall) begin
                r_pc        <= w_pc_next;
                r_irq_taken <= w_take;
            end
        end
    end

    assign pc          = r_pc;
    assign pc_inc      = {r_pc[WIDTH-1], w_low_inc};
    assign pc_offset   = {r_pc[WIDTH-1], w_low_off};
    assign supervisor  = r_pc[WIDTH-1];
    assign fetch_valid = (r_state == ST_RUN);
    assign irq_taken   = r_irq_taken;

endmodule
